// File: rtl/isa_pkg.sv
// Shared ISA-side types for the fetch predictors: counter encoding, BTB entry
// layout and the sequential PC increment.
package isa_pkg;

  typedef logic [31:0] word_t;

  // 2-bit saturating direction counter; MSB set means predict taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  // Tag field is sized for the default 16-entry table (pc[31:6]).
  localparam int BP_TAG_W = 26;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    word_t               target;
    bp_cnt_t             cnt;
    logic                is_jump;
  } btb_entry_t;

  localparam word_t BP_PC_INC = 32'd4;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:   1'b0,
    tag:     '0,
    target:  '0,
    cnt:     WNT,
    is_jump: 1'b0
  };

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating branch direction counter.
module bp_sat_counter
  import isa_pkg::*;
(
  input  bp_cnt_t cnt,
  input  logic    taken,
  output bp_cnt_t cnt_next
);

  // Step one state toward taken/not-taken, holding at the ends.
  always_comb begin
    cnt_next = cnt;
    case (cnt)
      SNT: cnt_next = taken ? WNT : SNT;
      WNT: cnt_next = taken ? WT  : SNT;
      WT:  cnt_next = taken ? ST  : WNT;
      ST:  cnt_next = taken ? ST  : WT;
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counter.
// Lookup is combinational from registered state (no same-cycle bypass);
// training is applied at the clock edge on a resolved branch/jump.
// Optional macro BP_PERF_CNT_EN adds saturating lookup/hit/mispredict counters.
module branch_predictor_btb
  import isa_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  output logic        btb_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] next_pc,
  input  logic        resolved,
  input  logic        update_btb,
  input  logic [31:0] update_pc,
  input  logic [31:0] branch_target,
  input  logic        branch_outcome,
  input  logic        br_jump,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_mispredicts,
`endif
  input  logic        miss
);

  btb_entry_t entry_q [ENTRIES];
  btb_entry_t entry_d [ENTRIES];

  // Index/tag split; pc[1:0] never participates. The tag is resized into the
  // fixed-width struct field (only exact for the default 16-entry table).
  logic [IDX_W-1:0]    fetch_idx;
  logic [TAG_W-1:0]    fetch_tag_full;
  logic [BP_TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag_full;
  logic [BP_TAG_W-1:0] upd_tag;

  assign fetch_idx      = fetch_pc[IDX_W+1:2];
  assign fetch_tag_full = fetch_pc[31:IDX_W+2];
  assign fetch_tag      = BP_TAG_W'(fetch_tag_full);
  assign upd_idx        = update_pc[IDX_W+1:2];
  assign upd_tag_full   = update_pc[31:IDX_W+2];
  assign upd_tag        = BP_TAG_W'(upd_tag_full);

  // Read-only lookup of the pre-update table state.
  btb_entry_t look_entry;
  always_comb begin
    look_entry  = entry_q[fetch_idx];
    btb_hit     = look_entry.valid && (look_entry.tag == fetch_tag);
    pred_taken  = btb_hit && (look_entry.is_jump || look_entry.cnt[1]);
    pred_target = btb_hit ? look_entry.target : '0;
    next_pc     = pred_taken ? pred_target : (fetch_pc + BP_PC_INC);
  end

  btb_entry_t upd_entry;
  logic       upd_hit;
  logic       upd_taken;
  bp_cnt_t    upd_cnt_next;

  assign upd_entry = entry_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
  assign upd_taken = br_jump || branch_outcome;

  bp_sat_counter u_sat_counter (
    .cnt      (upd_entry.cnt),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_next)
  );

  // Training: hits retrain counter/type (and target on update_btb); only
  // taken misses with a target allocate, evicting whatever shares the index.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (resolved && (upd_idx == IDX_W'(i))) begin
        if (upd_hit) begin
          entry_d[i].cnt     = upd_cnt_next;
          entry_d[i].is_jump = br_jump;
          if (update_btb) begin
            entry_d[i].target = branch_target;
          end
        end else if (upd_taken && update_btb) begin
          entry_d[i].valid   = 1'b1;
          entry_d[i].tag     = upd_tag;
          entry_d[i].target  = branch_target;
          entry_d[i].is_jump = br_jump;
          entry_d[i].cnt     = br_jump ? ST : WT;
        end
      end
    end
  end

  // Table state; reset wins over any coincident training.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (RST) begin
        entry_q[i] <= BTB_ENTRY_RESET;
      end else begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  // Saturating event counters.
  always_comb begin
    perf_lookups_d     = perf_lookups_q;
    perf_hits_d        = perf_hits_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (fetch_en && (perf_lookups_q != 32'hFFFF_FFFF)) begin
      perf_lookups_d = perf_lookups_q + 32'd1;
    end
    if (fetch_en && btb_hit && (perf_hits_q != 32'hFFFF_FFFF)) begin
      perf_hits_d = perf_hits_q + 32'd1;
    end
    if (resolved && miss && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
      perf_mispredicts_d = perf_mispredicts_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_lookups_q     <= '0;
      perf_hits_q        <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_lookups_q     <= perf_lookups_d;
      perf_hits_q        <= perf_hits_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_lookups     = perf_lookups_q;
  assign perf_hits        = perf_hits_q;
  assign perf_mispredicts = perf_mispredicts_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0]};
`else
  // fetch_en and miss only feed the optional counters.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], update_pc[1:0], fetch_en, miss};
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed self-checking bench for branch_predictor_btb (16 entries).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
// later, well before the next edge.
module tb_branch_predictor_btb;
  import isa_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic        resolved;
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] branch_target;
  logic        branch_outcome;
  logic        br_jump;
  logic        miss;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
  logic [31:0] perf_mispredicts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  branch_predictor_btb #(.ENTRIES(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .fetch_en       (fetch_en),
    .fetch_pc       (fetch_pc),
    .btb_hit        (btb_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .next_pc        (next_pc),
    .resolved       (resolved),
    .update_btb     (update_btb),
    .update_pc      (update_pc),
    .branch_target  (branch_target),
    .branch_outcome (branch_outcome),
    .br_jump        (br_jump),
`ifdef BP_PERF_CNT_EN
    .perf_lookups     (perf_lookups),
    .perf_hits        (perf_hits),
    .perf_mispredicts (perf_mispredicts),
`endif
    .miss           (miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("ok    %-22s observed=%h", tag, obs);
    end else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic outc, input logic jmp, input logic ub);
    resolved       = 1'b1;
    update_pc      = pc;
    branch_target  = tgt;
    branch_outcome = outc;
    br_jump        = jmp;
    update_btb     = ub;
  endtask

  task automatic clr_upd();
    resolved       = 1'b0;
    update_btb     = 1'b0;
    branch_outcome = 1'b0;
    br_jump        = 1'b0;
  endtask

  // One training event on 0x100, then look it up.
  task automatic train_100(input logic outc, input logic ub, input logic [31:0] tgt);
    set_upd(32'h100, tgt, outc, 1'b0, ub);
    tick();
    clr_upd();
    look(32'h100);
  endtask

  initial begin
    RST = 1'b1; fetch_en = 1'b0; fetch_pc = '0; miss = 1'b0;
    update_pc = '0; branch_target = '0;
    clr_upd();
    tick(); tick();
    RST = 1'b0;

    // Empty table after reset
    look(32'h100);
    chk("rst_hit",     {31'd0, btb_hit},    32'd0);
    chk("rst_taken",   {31'd0, pred_taken}, 32'd0);
    chk("rst_target",  pred_target,         32'h0);
    chk("rst_next_pc", next_pc,             32'h104);

    // Allocate taken branch 0x100 -> 0x200; not visible until after the edge
    set_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    look(32'h100);
    chk("alloc_same_cycle_hit", {31'd0, btb_hit}, 32'd0);
    tick();
    clr_upd();
    look(32'h100);
    chk("alloc_hit",     {31'd0, btb_hit},    32'd1);
    chk("alloc_taken",   {31'd0, pred_taken}, 32'd1);
    chk("alloc_target",  pred_target,         32'h200);
    chk("alloc_next_pc", next_pc,             32'h200);

    // WT -> ST -> ST -> ST; update_btb=0 must keep the stored target
    for (int i = 0; i < 3; i++) begin
      train_100(1'b1, 1'b0, 32'h999);
      chk("taken_train", {31'd0, pred_taken}, 32'd1);
    end
    chk("target_kept", pred_target, 32'h200);

    // ST -> WT (still taken) -> WNT (not taken)
    train_100(1'b0, 1'b0, 32'h0);
    chk("st_to_wt_taken", {31'd0, pred_taken}, 32'd1);
    train_100(1'b0, 1'b0, 32'h0);
    chk("wt_to_wnt_taken", {31'd0, pred_taken}, 32'd0);
    chk("wnt_hit",         {31'd0, btb_hit},    32'd1);
    chk("wnt_next_pc",     next_pc,             32'h104);
    // WNT -> SNT -> SNT
    train_100(1'b0, 1'b0, 32'h0);
    chk("snt_taken", {31'd0, pred_taken}, 32'd0);
    train_100(1'b0, 1'b0, 32'h0);
    chk("snt_hold_taken", {31'd0, pred_taken}, 32'd0);
    // SNT -> WNT (one taken not enough) -> WT with new target
    train_100(1'b1, 1'b0, 32'h0);
    chk("snt_to_wnt_taken", {31'd0, pred_taken}, 32'd0);
    train_100(1'b1, 1'b1, 32'h240);
    chk("wnt_to_wt_taken", {31'd0, pred_taken}, 32'd1);
    chk("retarget_next_pc", next_pc,            32'h240);

    // No allocation for not-taken misses, target-less misses, or resolved=0
    set_upd(32'h300, 32'h380, 1'b0, 1'b0, 1'b1);
    tick(); clr_upd(); look(32'h300);
    chk("nt_miss_no_alloc", {31'd0, btb_hit}, 32'd0);
    set_upd(32'h304, 32'h380, 1'b1, 1'b0, 1'b0);
    tick(); clr_upd(); look(32'h304);
    chk("no_ub_no_alloc", {31'd0, btb_hit}, 32'd0);
    set_upd(32'h308, 32'h380, 1'b1, 1'b0, 1'b1);
    resolved = 1'b0;
    tick(); clr_upd(); look(32'h308);
    chk("unresolved_no_alloc", {31'd0, btb_hit}, 32'd0);

    // JAL at 0x140 aliases 0x100 (index 0) and evicts it
    set_upd(32'h140, 32'h400, 1'b0, 1'b1, 1'b1);
    tick(); clr_upd();
    look(32'h100);
    chk("alias_old_hit",     {31'd0, btb_hit}, 32'd0);
    chk("alias_old_next_pc", next_pc,          32'h104);
    look(32'h140);
    chk("jal_hit",    {31'd0, btb_hit},    32'd1);
    chk("jal_taken",  {31'd0, pred_taken}, 32'd1);
    chk("jal_target", pred_target,         32'h400);

    // Same-cycle lookup/update on 0x180: pre-update view, then visible
    set_upd(32'h180, 32'h280, 1'b1, 1'b0, 1'b1);
    look(32'h180);
    chk("same_cycle_hit",     {31'd0, btb_hit}, 32'd0);
    chk("same_cycle_next_pc", next_pc,          32'h184);
    tick(); clr_upd();
    look(32'h182);
    chk("next_cycle_hit_lowbits", {31'd0, btb_hit}, 32'd1);
    chk("next_cycle_next_pc",     next_pc,          32'h280);
    look(32'h140);
    chk("evicted_jal_hit", {31'd0, btb_hit}, 32'd0);

    // Separate index stays independent
    set_upd(32'h104, 32'h800, 1'b0, 1'b1, 1'b1);
    tick(); clr_upd();
    look(32'h104);
    chk("idx1_target", pred_target, 32'h800);
    look(32'h144);
    chk("idx1_tag_miss", {31'd0, btb_hit}, 32'd0);

    // X on fetch_pc with fetch_en=0 must not disturb the table
    fetch_en = 1'b0;
    fetch_pc = 'x;
    tick(); tick();
    look(32'h104);
    chk("x_pc_state_kept", {31'd0, btb_hit}, 32'd1);

    // Reset with coincident allocating update: table cleared, no allocation
    set_upd(32'h1C0, 32'h500, 1'b1, 1'b0, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    clr_upd();
    look(32'h1C0);
    chk("rst_upd_discard_hit", {31'd0, btb_hit}, 32'd0);
    look(32'h180);
    chk("rst_clear_hit",     {31'd0, btb_hit},    32'd0);
    chk("rst_clear_taken",   {31'd0, pred_taken}, 32'd0);
    chk("rst_clear_target",  pred_target,         32'h0);
    chk("rst_clear_next_pc", next_pc,             32'h184);

    // Sequential PC wraps at 32 bits
    look(32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc, 32'h0);

`ifdef BP_PERF_CNT_EN
    RST = 1'b1; tick(); RST = 1'b0;
    chk("perf_rst_lookups", perf_lookups,     32'd0);
    chk("perf_rst_hits",    perf_hits,        32'd0);
    chk("perf_rst_mispred", perf_mispredicts, 32'd0);
    set_upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    tick(); clr_upd();
    // 5 lookups, 3 of them hit
    fetch_en = 1'b1;
    look(32'h100); tick();
    look(32'h100); tick();
    look(32'h600); tick();
    look(32'h100); tick();
    look(32'h700); tick();
    fetch_en = 1'b0;
    // Two resolved mispredicts, one unqualified miss pulse
    set_upd(32'h900, 32'h0, 1'b0, 1'b0, 1'b0);
    miss = 1'b1;
    tick(); tick();
    clr_upd();
    tick();
    miss = 1'b0;
    chk("perf_lookups", perf_lookups,     32'd5);
    chk("perf_hits",    perf_hits,        32'd3);
    chk("perf_mispred", perf_mispredicts, 32'd2);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("perf_clr_lookups", perf_lookups,     32'd0);
    chk("perf_clr_hits",    perf_hits,        32'd0);
    chk("perf_clr_mispred", perf_mispredicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
